// File: rtl/channel_scheduler.sv
// Two-source round-robin transmit scheduler: frames each grant as a header symbol
// plus a fixed payload burst, then holds a noise-only guard interval.
//
// state   | meaning
// IDLE    | channel quiet, waiting for a request
// HEADER  | header symbol of the granted source on channel_in
// PAYLOAD | payload symbols streaming from the granted source
// GUARD   | channel quiet for GUARD_LEN cycles after a burst or abort
module channel_scheduler #(
    parameter int         BURST_LEN = 4,
    parameter int         GUARD_LEN = 2,
    parameter logic [8:0] HDR0      = 9'h0F0,
    parameter logic [8:0] HDR1      = 9'h10F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [8:0] data0,
    input  logic [8:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       is_transmit,
    output logic [8:0] channel_in,
    output logic       active_src,
    output logic       busy,
    output logic       burst_done,
    output logic       abort
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        GUARD   = 2'd3
    } state_t;

    localparam logic [7:0] BL = BURST_LEN[7:0];
    localparam logic [7:0] GL = GUARD_LEN[7:0];

    state_t     state_q, state_d;
    logic       src_q, src_d;
    logic       last_src_q, last_src_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] gcnt_q, gcnt_d;
    logic       tx_q, tx_d;
    logic [8:0] ch_q, ch_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       abort_q, abort_d;

    logic       ack;
    logic       sel;
    logic       req_src;
    logic [8:0] data_src;

    assign req_src  = src_q ? req1 : req0;
    assign data_src = src_q ? data1 : data0;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        last_src_d = last_src_q;
        cnt_d      = cnt_q;
        gcnt_d     = gcnt_q;
        tx_d       = tx_q;
        ch_d       = ch_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        ack        = 1'b0;
        sel        = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b0;
                ch_d = 9'd0;
                if (req0 || req1) begin
                    // Tie goes to whichever source did not have the last grant
                    sel     = (req0 && req1) ? ~last_src_q : req1;
                    src_d   = sel;
                    tx_d    = 1'b1;
                    ch_d    = sel ? HDR1 : HDR0;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                ack = req_src;
                if (req_src) begin
                    ch_d    = data_src;
                    cnt_d   = 8'd1;
                    state_d = PAYLOAD;
                end else begin
                    tx_d       = 1'b0;
                    ch_d       = 9'd0;
                    abort_d    = 1'b1;
                    last_src_d = src_q;
                    gcnt_d     = 8'd1;
                    state_d    = GUARD;
                end
            end
            PAYLOAD: begin
                if (cnt_q == BL) begin
                    tx_d       = 1'b0;
                    ch_d       = 9'd0;
                    done_d     = 1'b1;
                    last_src_d = src_q;
                    gcnt_d     = 8'd1;
                    state_d    = GUARD;
                end else if (req_src) begin
                    ack   = 1'b1;
                    ch_d  = data_src;
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    tx_d       = 1'b0;
                    ch_d       = 9'd0;
                    abort_d    = 1'b1;
                    last_src_d = src_q;
                    gcnt_d     = 8'd1;
                    state_d    = GUARD;
                end
            end
            GUARD: begin
                tx_d = 1'b0;
                ch_d = 9'd0;
                if (gcnt_q == GL) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            src_q      <= 1'b0;
            last_src_q <= 1'b1;
            cnt_q      <= 8'd0;
            gcnt_q     <= 8'd0;
            tx_q       <= 1'b0;
            ch_q       <= 9'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            last_src_q <= last_src_d;
            cnt_q      <= cnt_d;
            gcnt_q     <= gcnt_d;
            tx_q       <= tx_d;
            ch_q       <= ch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    assign ack0        = ack & ~src_q;
    assign ack1        = ack & src_q;
    assign is_transmit = tx_q;
    assign channel_in  = ch_q;
    assign active_src  = src_q;
    assign busy        = busy_q;
    assign burst_done  = done_q;
    assign abort       = abort_q;

endmodule

// File: tb/tb_channel_scheduler.sv
// Directed bench for channel_scheduler: default instance plus a minimum-length instance.
module tb_channel_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, breq0, breq1;
    logic [8:0] data0, data1, bdata0, bdata1;
    logic       ack0, ack1, back0, back1;
    logic       is_transmit, active_src, busy, burst_done, abort;
    logic       b_is_transmit, b_active_src, b_busy, b_burst_done, b_abort;
    logic [8:0] channel_in, b_channel_in;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    channel_scheduler dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1),
        .is_transmit(is_transmit), .channel_in(channel_in),
        .active_src(active_src), .busy(busy),
        .burst_done(burst_done), .abort(abort)
    );

    channel_scheduler #(.BURST_LEN(1), .GUARD_LEN(1)) dut_min (
        .clk(clk), .reset(reset),
        .req0(breq0), .req1(breq1), .data0(bdata0), .data1(bdata1),
        .ack0(back0), .ack1(back1),
        .is_transmit(b_is_transmit), .channel_in(b_channel_in),
        .active_src(b_active_src), .busy(b_busy),
        .burst_done(b_burst_done), .abort(b_abort)
    );

    function automatic logic [15:0] e(input logic b, input logic a, input logic d,
                                      input logic ab, input logic t, input logic [8:0] ch);
        return {2'b00, b, a, d, ab, t, ch};
    endfunction

    function automatic logic [15:0] outa();
        return {2'b00, busy, active_src, burst_done, abort, is_transmit, channel_in};
    endfunction

    function automatic logic [15:0] outb();
        return {2'b00, b_busy, b_active_src, b_burst_done, b_abort, b_is_transmit, b_channel_in};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sources advance their symbol whenever their ack was high across the edge.
    task automatic tick();
        logic a0, a1, b0, b1;
        #1;
        a0 = ack0; a1 = ack1; b0 = back0; b1 = back1;
        @(posedge clk);
        #1;
        if (a0) data0 = data0 + 9'd1;
        if (a1) data1 = data1 + 9'd1;
        if (b0) bdata0 = bdata0 + 9'd1;
        if (b1) bdata1 = bdata1 + 9'd1;
        #1;
    endtask

    task automatic burst(input string tag, input logic s, input logic [8:0] hdr,
                         input logic [8:0] first);
        tick(); chk({tag, "_hdr"}, outa(), e(1, s, 0, 0, 1, hdr));
        chk({tag, "_ack"}, {14'd0, ack0, ack1}, s ? 16'd1 : 16'd2);
        for (int i = 0; i < 4; i++) begin
            tick(); chk({tag, "_pay"}, outa(), e(1, s, 0, 0, 1, first + 9'(i)));
        end
        tick(); chk({tag, "_done"}, outa(), e(1, s, 1, 0, 0, 9'd0));
        tick(); chk({tag, "_guard"}, outa(), e(1, s, 0, 0, 0, 9'd0));
        tick(); chk({tag, "_idle"}, outa(), e(0, s, 0, 0, 0, 9'd0));
    endtask

    initial begin
        reset = 1'b0;
        req0 = 1'($urandom); req1 = 1'($urandom);
        data0 = 9'($urandom); data1 = 9'($urandom);
        breq0 = 1'b0; breq1 = 1'b0; bdata0 = 9'd0; bdata1 = 9'd0;

        // Reset values
        #3;
        chk("rst_out", outa(), 16'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold", outa(), 16'd0);
        chk("rst_ack", {14'd0, ack0, ack1}, 16'd0);
        req0 = 1'b0; req1 = 1'b0;
        reset = 1'b1;
        tick(); chk("idle0", outa(), 16'd0);
        tick(); chk("idle1", outa(), 16'd0);

        // Single source, full burst
        data0 = 9'h011; req0 = 1'b1;
        tick(); chk("s_hdr", outa(), e(1, 0, 0, 0, 1, 9'h0F0));
        chk("s_ack", {14'd0, ack0, ack1}, 16'd2);
        tick(); chk("s_p1", outa(), e(1, 0, 0, 0, 1, 9'h011));
        tick(); chk("s_p2", outa(), e(1, 0, 0, 0, 1, 9'h012));
        tick(); chk("s_p3", outa(), e(1, 0, 0, 0, 1, 9'h013));
        tick(); chk("s_p4", outa(), e(1, 0, 0, 0, 1, 9'h014));
        chk("s_noack", {14'd0, ack0, ack1}, 16'd0);
        tick(); chk("s_done", outa(), e(1, 0, 1, 0, 0, 9'd0));
        tick(); chk("s_g2", outa(), e(1, 0, 0, 0, 0, 9'd0));
        tick(); chk("s_idle", outa(), e(0, 0, 0, 0, 0, 9'd0));
        tick(); chk("s_hdr2", outa(), e(1, 0, 0, 0, 1, 9'h0F0));
        req0 = 1'b0;
        #1;
        chk("h_abort_ack", {14'd0, ack0, ack1}, 16'd0);
        tick(); chk("h_abort", outa(), e(1, 0, 0, 1, 0, 9'd0));
        tick(); chk("h_guard", outa(), e(1, 0, 0, 0, 0, 9'd0));
        tick(); chk("h_idle", outa(), e(0, 0, 0, 0, 0, 9'd0));

        // Tie out of reset, then round-robin
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1; data0 = 9'h020; data1 = 9'h120;
        burst("rr0", 1'b0, 9'h0F0, 9'h020);
        burst("rr1", 1'b1, 9'h10F, 9'h120);
        burst("rr2", 1'b0, 9'h0F0, 9'h024);

        // Source 1 aborts after two payload acks
        tick(); chk("ab_hdr", outa(), e(1, 1, 0, 0, 1, 9'h10F));
        tick(); chk("ab_p1", outa(), e(1, 1, 0, 0, 1, 9'h124));
        tick(); chk("ab_p2", outa(), e(1, 1, 0, 0, 1, 9'h125));
        req1 = 1'b0;
        #1;
        chk("ab_noack", {14'd0, ack0, ack1}, 16'd0);
        tick(); chk("ab_pulse", outa(), e(1, 1, 0, 1, 0, 9'd0));
        tick(); chk("ab_g2", outa(), e(1, 1, 0, 0, 0, 9'd0));
        tick(); chk("ab_idle", outa(), e(0, 1, 0, 0, 0, 9'd0));
        req1 = 1'b1;
        tick(); chk("ab_next", outa(), e(1, 0, 0, 0, 1, 9'h0F0));
        for (int i = 0; i < 4; i++) begin
            tick(); chk("ab_pay0", outa(), e(1, 0, 0, 0, 1, 9'h028 + 9'(i)));
        end
        tick(); chk("ab_done0", outa(), e(1, 0, 1, 0, 0, 9'd0));
        tick(); tick();

        // Reset in PAYLOAD with cnt=2 while source 0 holds last_src
        tick(); chk("rm_hdr", outa(), e(1, 1, 0, 0, 1, 9'h10F));
        tick(); chk("rm_p1", outa(), e(1, 1, 0, 0, 1, 9'h126));
        tick(); chk("rm_p2", outa(), e(1, 1, 0, 0, 1, 9'h127));
        reset = 1'b0;
        #1;
        chk("rm_async", outa(), 16'd0);
        chk("rm_ack", {14'd0, ack0, ack1}, 16'd0);
        @(posedge clk);
        #1;
        chk("rm_hold", outa(), 16'd0);
        reset = 1'b1;
        tick(); chk("rm_tie", outa(), e(1, 0, 0, 0, 1, 9'h0F0));
        req0 = 1'b0; req1 = 1'b0;

        // Minimum lengths on the second instance
        breq0 = 1'b1; bdata0 = 9'h055;
        tick(); chk("min_hdr", outb(), e(1, 0, 0, 0, 1, 9'h0F0));
        tick(); chk("min_pay", outb(), e(1, 0, 0, 0, 1, 9'h055));
        chk("min_noack", {14'd0, back0, back1}, 16'd0);
        tick(); chk("min_done", outb(), e(1, 0, 1, 0, 0, 9'd0));
        tick(); chk("min_idle", outb(), e(0, 0, 0, 0, 0, 9'd0));
        tick(); chk("min_hdr2", outb(), e(1, 0, 0, 0, 1, 9'h0F0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/channel_scheduler.md
# channel_scheduler

Two-requester transmit scheduler that owns the noisy channel model's input side. It arbitrates round-robin between two symbol sources and frames each grant as a header symbol followed by a fixed-length payload burst. It enforces a guard interval between bursts so the receiver sees noise-only samples. Its `is_transmit` and `channel_in` outputs drive the channel block's `IsTransmit` and `channel_in` directly.

## Interface
- `BURST_LEN`, default 4: payload symbols per burst; legal range 1..255.
- `GUARD_LEN`, default 2: guard cycles after each burst or abort; legal range 1..255.
- `HDR0`, default 9'h0F0: header symbol for source 0.
- `HDR1`, default 9'h10F: header symbol for source 1.

Ports:
- `clk`  input  1: rising-edge clock.
- `reset`  input  1: asynchronous, active-low reset.
- `req0`, `req1`  input  1 each: source wants, or continues holding, the channel.
- `data0`, `data1`  input  9 each: current payload symbol of each source.
- `ack0`, `ack1`  output  1 each: combinational; the source's symbol is consumed at this rising edge.
- `is_transmit`  output  1: registered; drives the channel's `IsTransmit`.
- `channel_in`  output  9: registered; drives the channel's `channel_in`.
- `active_src`  output  1: registered; source of the current or last grant.
- `busy`  output  1: registered; high in HEADER, PAYLOAD and GUARD.
- `burst_done`  output  1: registered one-cycle pulse; burst completed normally.
- `abort`  output  1: registered one-cycle pulse; burst terminated by the requester.

## Operation
- States: IDLE, HEADER, PAYLOAD, GUARD.
- Internal registers: `src`, `last_src`, payload counter `cnt` (8 bit), guard counter `gcnt` (8 bit).
- **IDLE**
  - `is_transmit`=0, `channel_in`=0.
  - If either request is high at an edge, select a source:
    - only one request high: that source;
    - both high: `!last_src`.
  - On selection: `src`<=sel, `is_transmit`<=1, `channel_in`<=HDR(sel), go to HEADER.
- **HEADER**
  - Header symbol is on the output.
  - `ack_src` = `req_src`.
  - On ack: `channel_in`<=`data_src`, `cnt`<=1, go to PAYLOAD.
- **PAYLOAD**, `cnt` < BURST_LEN
  - `ack_src` = `req_src`.
  - On ack: `channel_in`<=`data_src`, `cnt`++.
- **PAYLOAD**, `cnt` == BURST_LEN
  - No ack.
  - Next edge: `is_transmit`<=0, `channel_in`<=0, `burst_done`<=1, `last_src`<=`src`, `gcnt`<=1, go to GUARD.
- **Abort**
  - Trigger: `req_src` low while in HEADER, or in PAYLOAD with `cnt` < BURST_LEN.
  - Next edge: `is_transmit`<=0, `channel_in`<=0, `abort`<=1, `last_src`<=`src`, `gcnt`<=1, go to GUARD.
  - No ack that cycle.
- **GUARD**
  - `is_transmit`=0, `channel_in`=0.
  - At the edge with `gcnt` == GUARD_LEN: go to IDLE; otherwise `gcnt`++.
  - Requests are ignored.
- The non-granted ack is always 0. `ack0` and `ack1` are never high together.
- Payload symbols pass through unmodified, as 9-bit values with no arithmetic applied. Noise addition belongs to the channel.

## Timing
- **Reset (asynchronous, active-low).** Takes effect immediately:
  - state=IDLE;
  - `is_transmit`=0, `channel_in`=0, `active_src`=0, `busy`=0, `burst_done`=0, `abort`=0;
  - `last_src`=1, so source 0 wins the first tie;
  - `cnt`=0, `gcnt`=0.
- **Reset mid-burst:** outputs drop to the reset values within the same cycle. No `burst_done` or `abort` pulse is produced.
- **Request to header:** request sampled high at edge N in IDLE → header on `channel_in` during cycle N+1.
- **Payload:** symbol acked at edge M appears on `channel_in` during cycle M+1.
- **Burst length:** an uninterrupted burst occupies 1+BURST_LEN transmit cycles.
- **Gap between consecutive bursts:** GUARD_LEN+1 non-transmit cycles (GUARD plus one IDLE cycle).
- **Pulses:** `burst_done` and `abort` are high during the first GUARD cycle only.
- `active_src` updates at the IDLE→HEADER edge.
- The channel block adds one further register stage downstream.

## Test plan
Default parameters unless stated.
1. **Reset values.** Hold `reset`=0 with random `req`/`data` → all outputs 0. Release and keep requests low → outputs stay 0.
2. **Single source, full burst.** `req0`=1; `data0` increments 9'h011..9'h014 on each `ack0`.
   - `channel_in` sequence: 0F0, 011, 012, 013, 014, with `is_transmit`=1 for 5 cycles.
   - Then `burst_done`=1 for 1 cycle, and `is_transmit`=0 for 3 cycles.
   - Next header appears in the 4th cycle after the burst.
3. **Tie and round-robin.** `req0` and `req1` rise together out of reset → source 0 first (HDR 0F0). Next grant goes to source 1 (HDR 10F), then back to source 0.
4. **Abort.** `req1` drops after 2 payload acks → `is_transmit`=0 in the next cycle.
   - `abort`=1 for 1 cycle; `burst_done` stays 0.
   - Guard lasts 2 cycles.
   - With both requesting, source 0 is granted next.
5. **Reset mid-payload.** Assert `reset` in the PAYLOAD cycle with `cnt`=2 → outputs 0 immediately. After release, a tie grants source 0.
6. **Minimum lengths.** BURST_LEN=1, GUARD_LEN=1 → exactly HDR plus 1 payload symbol, 1 guard cycle, 1 idle cycle, then the next header.
